// File: rtl/seq_det_sched.sv
// ============================================================================
// seq_det_sched : round-robin scheduler serializing words into a shared detector
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_det_sched #(
    parameter  int N       = 4,
    parameter  int W       = 8,
    parameter  int DET_LAT = 1,
    localparam int IW      = $clog2(N),
    localparam int CW      = $clog2(W+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic             det_rst,
    output logic             det_din,
    input  logic             det_pd,
    output logic             res_valid,
    output logic [IW-1:0]    res_id,
    output logic [CW-1:0]    res_count,
    input  logic             res_ready
);

    localparam int PW = $clog2(W+DET_LAT+1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_GRANT = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  word_q, word_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic          det_rst_q, det_rst_d;
    logic          det_din_q, det_din_d;
    logic [IW-1:0] w_win;

    // First valid requester strictly after the last-granted index, wrapping.
    always_comb begin
        int            j;
        logic          found;
        logic [IW-1:0] jj;
        w_win = ptr_q;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 1; k <= N; k++) begin
            j  = (int'(ptr_q) + k) % N;
            jj = IW'(j);
            if (!found && req_valid[jj]) begin
                found = 1'b1;
                w_win = jj;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        case (state_q)
            c_IDLE: begin
                if (|req_valid) begin
                    state_d = c_GRANT;
                    word_d  = req_data[int'(w_win)*W +: W];
                    id_d    = w_win;
                    ptr_d   = w_win;
                    cnt_d   = '0;
                end
            end
            c_GRANT: begin
                state_d = c_SHIFT;
                ph_d    = '0;
            end
            c_SHIFT, c_DRAIN: begin
                ph_d = ph_q + PW'(1);
                // Detector output lags the serial bit by DET_LAT, so the first
                // DET_LAT phases still reflect the freshly-reset detector.
                if (ph_q >= PW'(DET_LAT) && det_pd && cnt_q != CW'(W))
                    cnt_d = cnt_q + CW'(1);
                if (state_q == c_SHIFT && ph_q == PW'(W-1))
                    state_d = c_DRAIN;
                else if (state_q == c_DRAIN && ph_q == PW'(W+DET_LAT-1))
                    state_d = c_DONE;
            end
            c_DONE: begin
                if (res_ready)
                    state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase

        // Serial outputs are registered, so they are derived from the next state.
        det_rst_d = !(state_d == c_SHIFT || state_d == c_DRAIN);
        det_din_d = 1'b0;
        if (state_d == c_SHIFT) begin
            det_din_d = word_q[W-1];
            word_d    = {word_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_IDLE;
            word_q    <= '0;
            ptr_q     <= IW'(N-1);
            id_q      <= '0;
            cnt_q     <= '0;
            ph_q      <= '0;
            det_rst_q <= 1'b1;
            det_din_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            det_rst_q <= det_rst_d;
            det_din_q <= det_din_d;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++)
            req_ready[i] = (state_q == c_GRANT) && (id_q == IW'(i));
    end

    assign det_rst   = det_rst_q;
    assign det_din   = det_din_q;
    assign res_valid = (state_q == c_DONE);
    assign res_id    = id_q;
    assign res_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_det_sched.sv
// ============================================================================
// tb_seq_det_sched : directed bench with a 10110 overlapping Moore detector
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_seq_det_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        det_rst;
    logic        det_din;
    logic        det_pd;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [3:0]  res_count;
    logic        res_ready;

    int n_checks = 0;
    int n_fail   = 0;

    seq_det_sched #(.N(4), .W(8), .DET_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .det_rst   (det_rst),
        .det_din   (det_din),
        .det_pd    (det_pd),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_count (res_count),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    logic [4:0] hist = 5'd0;
    always @(posedge clk) begin
        if (det_rst) hist <= 5'd0;
        else         hist <= {hist[3:0], det_din};
    end
    assign det_pd = (hist == 5'b10110);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request mask and wait for the ack; returns inside the GRANT cycle.
    task automatic do_grant(input logic [3:0] valid, output logic [3:0] seen, output logic to);
        req_valid = valid;
        seen      = 4'b0;
        to        = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (req_ready != 4'b0) begin
                seen = req_ready;
                to   = 1'b0;
                break;
            end
        end
        req_valid = to ? 4'b0 : (req_valid & ~seen);
    endtask

    // From the GRANT cycle: record serial bits and cycles until res_valid.
    task automatic collect(output logic [7:0] bits, output int lat, output logic to);
        bits = 8'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            bits[7-i] = det_din;
        end
        lat = 8;
        to  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            lat++;
            if (res_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b0; req_data = 32'h0; res_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if (det_rst !== 1'b1 || req_ready !== 4'b0 || res_valid !== 1'b0 || res_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_during: det_rst=%b req_ready=%b res_valid=%b res_count=%0d, need 1 0000 0 0",
                     det_rst, req_ready, res_valid, res_count);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (det_rst !== 1'b1 || req_ready !== 4'b0 || res_valid !== 1'b0 || res_count !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: det_rst=%b req_ready=%b res_valid=%b res_count=%0d, need 1 0000 0 0",
                         c, det_rst, req_ready, res_valid, res_count);
            end
        end
    endtask

    task automatic test_single_word();
        logic [3:0] seen; logic [7:0] bits; int lat; logic to;
        req_data[7:0] = 8'b1011_0110;
        res_ready = 1'b1;
        do_grant(4'b0001, seen, to);
        n_checks++;
        if (to || seen !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b (timeout=%b), need 0001", seen, to);
        end
        collect(bits, lat, to);
        n_checks++;
        if (bits !== 8'b1011_0110) begin
            n_fail++;
            $display("FAIL single_din: got %b, need 10110110", bits);
        end
        n_checks++;
        if (to || lat != 10) begin
            n_fail++;
            $display("FAIL single_latency: got %0d (timeout=%b), need 10", lat, to);
        end
        n_checks++;
        if (res_id !== 2'd0 || res_count !== 4'd2) begin
            n_fail++;
            $display("FAIL single_result: id=%0d count=%0d, need id=0 count=2", res_id, res_count);
        end
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: res_valid=%b, need 0", res_valid);
        end
    endtask

    task automatic test_hold_result();
        logic [3:0] seen; logic [7:0] bits; int lat; logic to;
        req_data[23:16] = 8'h00;
        res_ready = 1'b0;
        do_grant(4'b0100, seen, to);
        n_checks++;
        if (to || seen !== 4'b0100) begin
            n_fail++;
            $display("FAIL hold_ready: got %b (timeout=%b), need 0100", seen, to);
        end
        collect(bits, lat, to);
        n_checks++;
        if (to || res_id !== 2'd2 || res_count !== 4'd0) begin
            n_fail++;
            $display("FAIL hold_result: id=%0d count=%0d timeout=%b, need id=2 count=0", res_id, res_count, to);
        end
        req_valid = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b1 || req_ready !== 4'b0 || res_id !== 2'd2 || res_count !== 4'd0) begin
                n_fail++;
                $display("FAIL hold_stall c%0d: res_valid=%b req_ready=%b id=%0d count=%0d, need 1 0000 2 0",
                         c, res_valid, req_ready, res_id, res_count);
            end
        end
        req_valid = 4'b0;
        res_ready = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: res_valid=%b, need 0", res_valid);
        end
    endtask

    task automatic test_cross_word();
        logic [3:0] seen; logic [7:0] bits; int lat; logic to;
        req_data[15:8]  = 8'b0000_1011;
        req_data[31:24] = 8'b0110_0000;
        do_grant(4'b0010, seen, to);
        collect(bits, lat, to);
        n_checks++;
        if (to || seen !== 4'b0010 || res_id !== 2'd1 || res_count !== 4'd0) begin
            n_fail++;
            $display("FAIL cross_first: ready=%b id=%0d count=%0d, need 0010 1 0", seen, res_id, res_count);
        end
        tick();
        do_grant(4'b1000, seen, to);
        collect(bits, lat, to);
        n_checks++;
        if (to || seen !== 4'b1000 || res_id !== 2'd3 || res_count !== 4'd0) begin
            n_fail++;
            $display("FAIL cross_second: ready=%b id=%0d count=%0d, need 1000 3 0", seen, res_id, res_count);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] seen; logic [7:0] bits; int lat; logic to;
        logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_data = 32'h0;
        for (int g = 0; g < 5; g++) begin
            do_grant(4'b1111, seen, to);
            n_checks++;
            if (to || seen !== exp_order[g]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b (timeout=%b), need %b", g, seen, to, exp_order[g]);
            end
            collect(bits, lat, to);
            req_valid = 4'b0;
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] seen; logic [7:0] bits; int lat; logic to;
        req_data[23:16] = 8'hFF;
        req_data[7:0]   = 8'b1011_0110;
        do_grant(4'b0100, seen, to);
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (det_din !== 1'b1 || det_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_pre: det_din=%b det_rst=%b, need 1 0", det_din, det_rst);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (det_rst !== 1'b1 || det_din !== 1'b0 || req_ready !== 4'b0 || res_valid !== 1'b0 ||
            res_id !== 2'd0 || res_count !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_now: det_rst=%b det_din=%b req_ready=%b res_valid=%b id=%0d count=%0d, need 1 0 0000 0 0 0",
                     det_rst, det_din, req_ready, res_valid, res_id, res_count);
        end
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_novalid c%0d: res_valid=%b, need 0", c, res_valid);
            end
        end
        do_grant(4'b0101, seen, to);
        n_checks++;
        if (to || seen !== 4'b0001) begin
            n_fail++;
            $display("FAIL areset_prio: got %b (timeout=%b), need 0001", seen, to);
        end
        req_valid = 4'b0;
        collect(bits, lat, to);
        n_checks++;
        if (to || res_id !== 2'd0 || res_count !== 4'd2) begin
            n_fail++;
            $display("FAIL areset_result: id=%0d count=%0d timeout=%b, need id=0 count=2", res_id, res_count, to);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_hold_result();
        test_cross_word();
        test_round_robin();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
